// File: rtl/axi_err_responder_pkg.sv
// AXI4 channel and bundle types used as the default request/response types of the error responder.
package axi_err_responder_pkg;

    localparam int IdWidth   = 4;
    localparam int AddrWidth = 32;
    localparam int DataWidth = 64;
    localparam int UserWidth = 1;

    typedef logic [IdWidth-1:0]     id_t;
    typedef logic [AddrWidth-1:0]   addr_t;
    typedef logic [DataWidth-1:0]   data_t;
    typedef logic [DataWidth/8-1:0] strb_t;
    typedef logic [UserWidth-1:0]   user_t;

    typedef struct packed {
        id_t         id;
        addr_t       addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        user_t       user;
    } aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } w_chan_t;

    typedef struct packed {
        id_t        id;
        logic [1:0] resp;
        user_t      user;
    } b_chan_t;

    typedef struct packed {
        id_t         id;
        addr_t       addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        user_t       user;
    } ar_chan_t;

    typedef struct packed {
        id_t        id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } axi_resp_t;

endpackage

// File: rtl/axi_err_responder.sv
// Terminates every AXI4 transaction with a fixed error response; writes are discarded and reads
// return a constant data pattern. All outputs are decoded from registered state only.
//
// state  | meaning
// W_IDLE | waiting for AW, aw_ready high
// W_DATA | AW accepted, sinking W beats until last
// W_RESP | presenting B until b_ready
// R_IDLE | waiting for AR, ar_ready high
// R_DATA | streaming len+1 R beats
module axi_err_responder
    import axi_err_responder_pkg::*;
#(
    parameter logic [1:0]  Resp     = 2'b11,
    parameter logic [63:0] RespData = 64'hCA11_AB1E_BADC_AB1E,
    parameter type         req_t    = axi_req_t,
    parameter type         resp_t   = axi_resp_t
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o
);

    localparam int AwIdW  = $bits(slv_req_i.aw.id);
    localparam int ArIdW  = $bits(slv_req_i.ar.id);
    localparam int RDataW = $bits(slv_resp_o.r.data);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    w_state_e         w_state_q, w_state_d;
    r_state_e         r_state_q, r_state_d;
    logic [AwIdW-1:0] aw_id_q;
    logic [ArIdW-1:0] ar_id_q;
    logic [7:0]       r_len_q;
    logic [7:0]       r_cnt_q;
    logic [7:0]       w_cnt_q;

    logic aw_hs, w_hs, ar_hs, r_hs, r_last;

    assign aw_hs  = (w_state_q == W_IDLE) && slv_req_i.aw_valid;
    assign w_hs   = (w_state_q == W_DATA) && slv_req_i.w_valid;
    assign ar_hs  = (r_state_q == R_IDLE) && slv_req_i.ar_valid;
    assign r_hs   = (r_state_q == R_DATA) && slv_req_i.r_ready;
    assign r_last = (r_cnt_q == r_len_q);

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (slv_req_i.aw_valid) w_state_d = W_DATA;
            W_DATA:  if (slv_req_i.w_valid && slv_req_i.w.last) w_state_d = W_RESP;
            W_RESP:  if (slv_req_i.b_ready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (slv_req_i.ar_valid) r_state_d = R_DATA;
            R_DATA:  if (slv_req_i.r_ready && r_last) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            aw_id_q   <= '0;
            w_cnt_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            if (aw_hs) begin
                aw_id_q <= slv_req_i.aw.id;
                w_cnt_q <= '0;
            end else if (w_hs) begin
                w_cnt_q <= w_cnt_q + 8'd1;
            end
        end
    end

    // The beat counter never needs to wrap: the last beat (cnt == len, at most 255) returns to idle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            ar_id_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                ar_id_q <= slv_req_i.ar.id;
                r_len_q <= slv_req_i.ar.len;
                r_cnt_q <= '0;
            end else if (r_hs) begin
                r_cnt_q <= r_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = (w_state_q == W_IDLE);
        slv_resp_o.w_ready  = (w_state_q == W_DATA);
        slv_resp_o.b_valid  = (w_state_q == W_RESP);
        slv_resp_o.b.id     = aw_id_q;
        slv_resp_o.b.resp   = Resp;
        slv_resp_o.ar_ready = (r_state_q == R_IDLE);
        slv_resp_o.r_valid  = (r_state_q == R_DATA);
        slv_resp_o.r.id     = ar_id_q;
        slv_resp_o.r.resp   = Resp;
        if (r_state_q == R_DATA) begin
            slv_resp_o.r.data = RDataW'(RespData);
            slv_resp_o.r.last = r_last;
        end
    end

    // Address, attribute and write-data fields are intentionally discarded.
    logic unused_inputs;
    assign unused_inputs = ^{slv_req_i, w_cnt_q};

endmodule

// File: tb/tb_axi_err_responder.sv
// Directed bench for axi_err_responder: default DECERR instance plus a SLVERR instance.
module tb_axi_err_responder;
    import axi_err_responder_pkg::*;

    localparam logic [63:0] RData = 64'hCA11_AB1E_BADC_AB1E;

    logic      clk;
    logic      rst_n;
    axi_req_t  req, req2;
    axi_resp_t resp, resp2;

    int n_cmp = 0;
    int n_mis = 0;

    axi_err_responder dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (req),
        .slv_resp_o (resp)
    );

    axi_err_responder #(.Resp(2'b10)) dut_slv (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (req2),
        .slv_resp_o (resp2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  beats;
        int  rbeats;
        bit  done;

        rst_n = 1'b0;
        req   = '0;
        req2  = '0;
        tick();
        tick();

        // reset state
        chk("rst_aw_ready", 64'(resp.aw_ready), 64'd1);
        chk("rst_ar_ready", 64'(resp.ar_ready), 64'd1);
        chk("rst_w_ready",  64'(resp.w_ready),  64'd0);
        chk("rst_b_valid",  64'(resp.b_valid),  64'd0);
        chk("rst_r_valid",  64'(resp.r_valid),  64'd0);
        chk("rst_b_id",     64'(resp.b.id),     64'd0);
        chk("rst_b_resp",   64'(resp.b.resp),   64'd3);
        chk("rst_r_id",     64'(resp.r.id),     64'd0);
        chk("rst_r_data",   64'(resp.r.data),   64'd0);
        chk("rst_r_last",   64'(resp.r.last),   64'd0);
        chk("rst_r_resp",   64'(resp.r.resp),   64'd3);
        rst_n = 1'b1;
        tick();

        // W presented 5 cycles ahead of AW: must not be accepted
        req.w_valid = 1'b1;
        req.w.last  = 1'b0;
        req.w.data  = 64'h1234_5678_9ABC_DEF0;
        req.w.strb  = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            chk("w_early_no_ready", 64'(resp.w_ready), 64'd0);
            tick();
        end
        req.aw_valid = 1'b1;
        req.aw.id    = 4'd5;
        req.aw.addr  = 32'hDEAD_0000;
        req.aw.len   = 8'd3;
        chk("aw_ready_idle", 64'(resp.aw_ready), 64'd1);
        tick();
        req.aw_valid = 1'b0;
        chk("aw_ready_busy", 64'(resp.aw_ready), 64'd0);
        chk("w_ready_after_aw", 64'(resp.w_ready), 64'd1);
        chk("b_valid_in_data", 64'(resp.b_valid), 64'd0);
        for (int b = 1; b <= 4; b++) begin
            req.w.last = (b == 4);
            chk("w_ready_beat", 64'(resp.w_ready), 64'd1);
            tick();
            chk("b_valid_timing", 64'(resp.b_valid), (b == 4) ? 64'd1 : 64'd0);
        end
        req.w_valid = 1'b0;
        chk("w_ready_in_resp", 64'(resp.w_ready), 64'd0);
        chk("b_id", 64'(resp.b.id), 64'd5);
        chk("b_resp", 64'(resp.b.resp), 64'd3);
        chk("b_user", 64'(resp.b.user), 64'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("b_hold_valid", 64'(resp.b_valid), 64'd1);
            chk("b_hold_id", 64'(resp.b.id), 64'd5);
            chk("no_aw_while_b", 64'(resp.aw_ready), 64'd0);
        end
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
        chk("b_done_valid", 64'(resp.b_valid), 64'd0);
        chk("b_done_aw_ready", 64'(resp.aw_ready), 64'd1);

        // AR id=3 len=7 with r_ready high
        req.ar_valid = 1'b1;
        req.ar.id    = 4'd3;
        req.ar.len   = 8'd7;
        req.r_ready  = 1'b1;
        tick();
        req.ar_valid = 1'b0;
        chk("ar_ready_busy", 64'(resp.ar_ready), 64'd0);
        for (int b = 1; b <= 8; b++) begin
            chk("r8_valid", 64'(resp.r_valid), 64'd1);
            chk("r8_data", 64'(resp.r.data), RData);
            chk("r8_id", 64'(resp.r.id), 64'd3);
            chk("r8_last", 64'(resp.r.last), (b == 8) ? 64'd1 : 64'd0);
            tick();
        end
        chk("r8_end_valid", 64'(resp.r_valid), 64'd0);
        chk("r8_end_ar_ready", 64'(resp.ar_ready), 64'd1);

        // AR len=255 with random r_ready
        req.ar_valid = 1'b1;
        req.ar.id    = 4'd9;
        req.ar.len   = 8'd255;
        tick();
        req.ar_valid = 1'b0;
        beats = 0;
        done  = 1'b0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            if (resp.r_valid) begin
                chk("r256_last", 64'(resp.r.last), (beats == 255) ? 64'd1 : 64'd0);
                chk("r256_data", 64'(resp.r.data), RData);
                chk("r256_id", 64'(resp.r.id), 64'd9);
                req.r_ready = 1'($urandom_range(0, 1));
                if (req.r_ready) beats++;
                tick();
            end else begin
                done = 1'b1;
            end
        end
        chk("r256_finished", 64'(done), 64'd1);
        chk("r256_beats", 64'(beats), 64'd256);
        req.r_ready = 1'b1;

        // simultaneous AW and AR, B held off for 10 cycles
        req.aw_valid = 1'b1;
        req.aw.id    = 4'd6;
        req.ar_valid = 1'b1;
        req.ar.id    = 4'd2;
        req.ar.len   = 8'd3;
        req.b_ready  = 1'b0;
        tick();
        chk("dual_aw_taken", 64'(resp.aw_ready), 64'd0);
        chk("dual_ar_taken", 64'(resp.ar_ready), 64'd0);
        chk("dual_w_ready", 64'(resp.w_ready), 64'd1);
        chk("dual_r_valid", 64'(resp.r_valid), 64'd1);
        req.aw_valid = 1'b0;
        req.ar_valid = 1'b0;
        req.w_valid  = 1'b1;
        req.w.last   = 1'b1;
        rbeats = 0;
        if (resp.r_valid) rbeats++;
        tick();
        req.w_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("dual_b_valid", 64'(resp.b_valid), 64'd1);
            chk("dual_b_id", 64'(resp.b.id), 64'd6);
            chk("dual_b_resp", 64'(resp.b.resp), 64'd3);
            if (resp.r_valid) rbeats++;
            tick();
        end
        chk("dual_r_beats", 64'(rbeats), 64'd4);
        chk("dual_r_done", 64'(resp.r_valid), 64'd0);
        chk("dual_ar_ready", 64'(resp.ar_ready), 64'd1);
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
        chk("dual_b_done", 64'(resp.b_valid), 64'd0);
        chk("dual_aw_ready", 64'(resp.aw_ready), 64'd1);

        // reset during beat 3 of a len=7 read
        req.ar_valid = 1'b1;
        req.ar.id    = 4'd4;
        req.ar.len   = 8'd7;
        tick();
        req.ar_valid = 1'b0;
        tick();
        tick();
        chk("midrst_beat3_valid", 64'(resp.r_valid), 64'd1);
        chk("midrst_beat3_last", 64'(resp.r.last), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_r_valid", 64'(resp.r_valid), 64'd0);
        chk("midrst_ar_ready", 64'(resp.ar_ready), 64'd1);
        chk("midrst_r_id", 64'(resp.r.id), 64'd0);
        req.ar_valid = 1'b1;
        req.ar.id    = 4'd1;
        req.ar.len   = 8'd7;
        tick();
        req.ar_valid = 1'b0;
        for (int b = 1; b <= 8; b++) begin
            chk("postrst_valid", 64'(resp.r_valid), 64'd1);
            chk("postrst_id", 64'(resp.r.id), 64'd1);
            chk("postrst_last", 64'(resp.r.last), (b == 8) ? 64'd1 : 64'd0);
            tick();
        end
        chk("postrst_end", 64'(resp.r_valid), 64'd0);

        // SLVERR instance: atomic AW gets only B, then a single-beat read
        req2.aw_valid = 1'b1;
        req2.aw.id    = 4'd2;
        req2.aw.atop  = 6'h20;
        tick();
        req2.aw_valid = 1'b0;
        req2.w_valid  = 1'b1;
        req2.w.last   = 1'b1;
        tick();
        req2.w_valid = 1'b0;
        chk("slv_b_valid", 64'(resp2.b_valid), 64'd1);
        chk("slv_b_resp", 64'(resp2.b.resp), 64'd2);
        chk("slv_b_id", 64'(resp2.b.id), 64'd2);
        chk("atop_no_r", 64'(resp2.r_valid), 64'd0);
        req2.b_ready = 1'b1;
        tick();
        req2.b_ready = 1'b0;
        chk("atop_no_r_after_b", 64'(resp2.r_valid), 64'd0);
        chk("slv_b_done", 64'(resp2.b_valid), 64'd0);
        req2.ar_valid = 1'b1;
        req2.ar.id    = 4'd5;
        req2.ar.len   = 8'd0;
        tick();
        req2.ar_valid = 1'b0;
        chk("slv_r_valid", 64'(resp2.r_valid), 64'd1);
        chk("slv_r_resp", 64'(resp2.r.resp), 64'd2);
        chk("slv_r_last", 64'(resp2.r.last), 64'd1);
        chk("slv_r_data", 64'(resp2.r.data), RData);
        tick();
        chk("slv_r_stall", 64'(resp2.r_valid), 64'd1);
        req2.r_ready = 1'b1;
        tick();
        req2.r_ready = 1'b0;
        chk("slv_r_done", 64'(resp2.r_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
